// File: rtl/biquad8_loader_pkg.sv
// biquad8_loader_pkg
//   Shared definitions for the biquad8 coefficient loader: FSM state encoding,
//   biquad8 register offsets, control-register bit positions, the control words
//   the loader writes, and the layout of one program RAM entry.
package biquad8_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BYP_ENTER,   // bypass-on write in flight (safe-bypass builds only)
        ST_FETCH,       // program RAM read issued
        ST_LATCH,       // RAM data valid, entry handed to the write engine
        ST_WRITE,       // entry write in flight
        ST_ARM,         // bus idle for one cycle, commit write launched
        ST_COMMIT,      // commit write in flight
        ST_DONE
    } state_e;

    // biquad8 register map
    localparam logic [6:0] REG_CTRL    = 7'h00;
    localparam logic [6:0] REG_FIR     = 7'h04;
    localparam logic [6:0] REG_IIR     = 7'h08;
    localparam logic [6:0] REG_INC     = 7'h0C;
    localparam logic [6:0] REG_POLEFIR = 7'h10;

    // REG_CTRL bit positions
    localparam int CTRL_UPDATE     = 0;
    localparam int CTRL_BYP_VAL    = 16;
    localparam int CTRL_BYP_APPLY  = 23;
    localparam int CTRL_MASK_APPLY = 31;

    // Bypass apply with value 0: filter held in local bypass.
    localparam logic [31:0] BYP_ENTER_WORD = 32'h0080_0000;
    // Bypass apply with value 1 plus update: leave bypass and load new set at once.
    localparam logic [31:0] BYP_EXIT_WORD  = 32'h0081_0001;

    localparam logic [3:0] SEL_ALL    = 4'hF;
    localparam logic [3:0] SEL_UPDATE = 4'b0001;
    localparam logic [3:0] SEL_BYP    = 4'b0101;

    typedef struct packed {
        logic [6:0]  adr;
        logic [31:0] dat;
    } prog_entry_t;

endpackage

// File: rtl/biquad8_wb_single_write.sv
// biquad8_wb_single_write
//   Single-beat WISHBONE write engine with response timeout. A start pulse
//   captures address/data/select and raises cyc/stb/we on the next edge; they
//   drop on the edge after ack, err, rty, timeout or abort.
// Ports:
//   wb_clk_i, wb_rst_n_i   clock, asynchronous active-low reset
//   start                  launch a write (only issued while idle)
//   abort                  drop the cycle immediately
//   adr, dat, sel          write parameters, sampled with start
//   ok                     write acknowledged this cycle
//   fail                   err/rty/timeout this cycle
//   wb_*                   WISHBONE master signals
module biquad8_wb_single_write #(
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        start,
    input  logic        abort,
    input  logic [6:0]  adr,
    input  logic [31:0] dat,
    input  logic [3:0]  sel,
    output logic        ok,
    output logic        fail,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [6:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i
);

    // Timer counts completed cycles with cyc high; the last allowed cycle is
    // TIMEOUT-1, so cyc stays up for exactly TIMEOUT cycles without a response.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic        cyc_q;
    logic [15:0] tmr_q;
    logic [6:0]  adr_q;
    logic [31:0] dat_q;
    logic [3:0]  sel_q;
    logic        tmo_hit;

    assign tmo_hit = (tmr_q == TMO_LAST);
    // A late ack in the final timeout cycle still counts as success.
    assign ok   = cyc_q & wb_ack_i & ~wb_err_i & ~wb_rty_i;
    assign fail = cyc_q & (wb_err_i | wb_rty_i | (tmo_hit & ~wb_ack_i));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            cyc_q <= 1'b0;
            tmr_q <= '0;
            adr_q <= '0;
            dat_q <= '0;
            sel_q <= '0;
        end else if (start) begin
            cyc_q <= 1'b1;
            tmr_q <= '0;
            adr_q <= adr;
            dat_q <= dat;
            sel_q <= sel;
        end else if (cyc_q) begin
            if (abort || ok || fail) begin
                cyc_q <= 1'b0;
            end
            tmr_q <= tmr_q + 16'd1;
        end
    end

    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = cyc_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = sel_q;

endmodule

// File: rtl/biquad8_coeff_loader.sv
// biquad8_coeff_loader
//   WISHBONE master that programs one biquad8 slot from a coefficient program
//   in block RAM: one single-beat write per (adr, dat) entry, then a commit
//   write to REG_CTRL. Reports done with a sticky error status.
//   Optional feature macro: BQ_LOADER_SAFE_BYPASS_EN -- when defined, a bypass
//   enter write precedes the entries and the commit also leaves bypass.
// Ports:
//   wb_clk_i, wb_rst_n_i     clock, asynchronous active-low reset
//   start_i, base_i, count_i start pulse, first entry, number of entries
//   abort_i                  terminate the running sequence with error
//   busy_o, done_o           sequence active, one-cycle completion pulse
//   err_o, err_idx_o         sticky error of last sequence, failing index
//   prog_adr_o, prog_en_o    program RAM read port, data one cycle later
//   prog_dat_i               {adr[6:0], dat[31:0]}
//   wb_*                     WISHBONE master to the biquad register space
module biquad8_coeff_loader
    import biquad8_loader_pkg::*;
#(
    parameter int          PROG_ADDR_BITS = 8,
    parameter int          TIMEOUT        = 255,
    parameter logic [31:0] UPDATE_WORD    = 32'h0000_0001
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_n_i,
    input  logic                      start_i,
    input  logic [PROG_ADDR_BITS-1:0] base_i,
    input  logic [PROG_ADDR_BITS:0]   count_i,
    input  logic                      abort_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [PROG_ADDR_BITS:0]   err_idx_o,
    output logic [PROG_ADDR_BITS-1:0] prog_adr_o,
    output logic                      prog_en_o,
    input  logic [38:0]               prog_dat_i,
    output logic                      wb_cyc_o,
    output logic                      wb_stb_o,
    output logic                      wb_we_o,
    output logic [6:0]                wb_adr_o,
    output logic [31:0]               wb_dat_o,
    output logic [3:0]                wb_sel_o,
    input  logic                      wb_ack_i,
    input  logic                      wb_err_i,
    input  logic                      wb_rty_i
);

    localparam int IW = PROG_ADDR_BITS + 1;

`ifdef BQ_LOADER_SAFE_BYPASS_EN
    localparam logic [31:0] COMMIT_WORD = BYP_EXIT_WORD;
    localparam logic [3:0]  COMMIT_SEL  = SEL_BYP;
`else
    localparam logic [31:0] COMMIT_WORD = UPDATE_WORD;
    localparam logic [3:0]  COMMIT_SEL  = SEL_UPDATE;
`endif

    state_e                    state_q, state_d;
    logic [PROG_ADDR_BITS-1:0] ptr_q;
    logic [IW-1:0]             idx_q;
    logic [IW-1:0]             cnt_q;
    logic                      err_q;
    logic [IW-1:0]             err_idx_q;

    logic                      wr_go;
    logic [6:0]                wr_adr;
    logic [31:0]               wr_dat;
    logic [3:0]                wr_sel;
    logic                      wr_ok;
    logic                      wr_fail;
    logic                      accept;
    logic                      entry_done;
    logic                      seq_err;
    logic                      last_entry;
    prog_entry_t               entry;

    assign entry      = prog_entry_t'(prog_dat_i);
    assign last_entry = ((idx_q + IW'(1)) == cnt_q);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        wr_go      = 1'b0;
        wr_adr     = REG_CTRL;
        wr_dat     = COMMIT_WORD;
        wr_sel     = COMMIT_SEL;
        accept     = 1'b0;
        entry_done = 1'b0;
        seq_err    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    accept = 1'b1;
`ifdef BQ_LOADER_SAFE_BYPASS_EN
                    wr_go   = 1'b1;
                    wr_dat  = BYP_ENTER_WORD;
                    wr_sel  = SEL_BYP;
                    state_d = ST_BYP_ENTER;
`else
                    if (count_i == '0) begin
                        wr_go   = 1'b1;
                        state_d = ST_COMMIT;
                    end else begin
                        state_d = ST_FETCH;
                    end
`endif
                end
            end

            ST_BYP_ENTER: begin
                if (abort_i || wr_fail) begin
                    seq_err = 1'b1;
                    state_d = ST_DONE;
                end else if (wr_ok) begin
                    state_d = (cnt_q == '0) ? ST_ARM : ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (abort_i) begin
                    seq_err = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_LATCH;
                end
            end

            ST_LATCH: begin
                if (abort_i) begin
                    seq_err = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wr_go   = 1'b1;
                    wr_adr  = entry.adr;
                    wr_dat  = entry.dat;
                    wr_sel  = SEL_ALL;
                    state_d = ST_WRITE;
                end
            end

            // Abort is tested before ack so a simultaneous ack still reports
            // this entry as the failing index.
            ST_WRITE: begin
                if (abort_i || wr_fail) begin
                    seq_err = 1'b1;
                    state_d = ST_DONE;
                end else if (wr_ok) begin
                    entry_done = 1'b1;
                    state_d    = last_entry ? ST_ARM : ST_FETCH;
                end
            end

            // One idle bus cycle between the last entry and the commit write.
            ST_ARM: begin
                if (abort_i) begin
                    seq_err = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wr_go   = 1'b1;
                    state_d = ST_COMMIT;
                end
            end

            ST_COMMIT: begin
                if (abort_i || wr_fail) begin
                    seq_err = 1'b1;
                    state_d = ST_DONE;
                end else if (wr_ok) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ptr_q     <= base_i;
                idx_q     <= '0;
                cnt_q     <= count_i;
                err_q     <= 1'b0;
                err_idx_q <= '0;
            end
            // Pointer wraps naturally modulo 2^PROG_ADDR_BITS.
            if (entry_done) begin
                ptr_q <= ptr_q + PROG_ADDR_BITS'(1);
                idx_q <= idx_q + IW'(1);
            end
            if (seq_err) begin
                err_q     <= 1'b1;
                err_idx_q <= idx_q;
            end
        end
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DONE);
    assign prog_en_o  = (state_q == ST_FETCH);
    assign prog_adr_o = ptr_q;
    assign err_o      = err_q;
    assign err_idx_o  = err_idx_q;

    biquad8_wb_single_write #(
        .TIMEOUT (TIMEOUT)
    ) u_wr (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n_i (wb_rst_n_i),
        .start      (wr_go),
        .abort      (abort_i),
        .adr        (wr_adr),
        .dat        (wr_dat),
        .sel        (wr_sel),
        .ok         (wr_ok),
        .fail       (wr_fail),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i),
        .wb_rty_i   (wb_rty_i)
    );

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// tb_biquad8_coeff_loader
//   Directed bench for biquad8_coeff_loader: a synchronous program RAM model,
//   a WISHBONE target with programmable ack latency / error / silence, and a
//   log of every write and RAM read compared against hand-built expectations.
//   Expectations follow BQ_LOADER_SAFE_BYPASS_EN when it is defined.
`timescale 1ns/1ps
module tb_biquad8_coeff_loader;

    localparam int AW  = 8;
    localparam int TMO = 8;

    logic          wb_clk_i   = 1'b0;
    logic          wb_rst_n_i = 1'b0;
    logic          start_i    = 1'b0;
    logic [AW-1:0] base_i     = '0;
    logic [AW:0]   count_i    = '0;
    logic          abort_i    = 1'b0;
    logic          busy_o, done_o, err_o, prog_en_o;
    logic [AW:0]   err_idx_o;
    logic [AW-1:0] prog_adr_o;
    logic [38:0]   prog_dat_i = '0;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [6:0]    wb_adr_o;
    logic [31:0]   wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic          wb_ack_i = 1'b0;
    logic          wb_err_i = 1'b0;
    logic          wb_rty_i = 1'b0;

    biquad8_coeff_loader #(
        .PROG_ADDR_BITS (AW),
        .TIMEOUT        (TMO),
        .UPDATE_WORD    (32'h0000_0001)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n_i (wb_rst_n_i),
        .start_i    (start_i),
        .base_i     (base_i),
        .count_i    (count_i),
        .abort_i    (abort_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .err_idx_o  (err_idx_o),
        .prog_adr_o (prog_adr_o),
        .prog_en_o  (prog_en_o),
        .prog_dat_i (prog_dat_i),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i),
        .wb_rty_i   (wb_rty_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Synchronous program RAM: data one cycle after the enable.
    logic [38:0] ram [256];
    always @(posedge wb_clk_i) begin
        if (prog_en_o) prog_dat_i <= ram[prog_adr_o];
    end

    typedef struct packed {
        logic [6:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wr_t;

    wr_t           wlog[$];
    wr_t           exp_w[$];
    logic [AW-1:0] rlog[$];

    int tgt_lat    = 2;
    bit tgt_never  = 1'b0;
    int tgt_err_at = -1;
    int wait_cnt   = 0;
    int last_hi    = 0;
    int bad_strobe = 0;
    int done_seen  = 0;

    // Target and monitors, driven/sampled on the falling edge.
    always @(negedge wb_clk_i) begin
        if (prog_en_o) rlog.push_back(prog_adr_o);
        if (done_o) done_seen++;
        if (wb_cyc_o) begin
            if (wait_cnt == 0) wlog.push_back('{wb_adr_o, wb_dat_o, wb_sel_o});
            if (!(wb_stb_o && wb_we_o)) bad_strobe++;
            wait_cnt++;
            last_hi = wait_cnt;
            if (!tgt_never && wait_cnt == tgt_lat) begin
                if (wlog.size() - 1 == tgt_err_at) wb_err_i = 1'b1;
                else                                wb_ack_i = 1'b1;
            end else begin
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
            end
        end else begin
            wait_cnt = 0;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
        end
    end

    task automatic exp_begin();
        exp_w.delete();
`ifdef BQ_LOADER_SAFE_BYPASS_EN
        exp_w.push_back('{7'h00, 32'h0080_0000, 4'b0101});
`endif
    endtask

    task automatic exp_entry(input logic [AW-1:0] a);
        logic [38:0] e;
        e = ram[a];
        exp_w.push_back('{e[38:32], e[31:0], 4'hF});
    endtask

    task automatic exp_commit();
`ifdef BQ_LOADER_SAFE_BYPASS_EN
        exp_w.push_back('{7'h00, 32'h0081_0001, 4'b0101});
`else
        exp_w.push_back('{7'h00, 32'h0000_0001, 4'b0001});
`endif
    endtask

    task automatic check_writes(input string tag);
        int n;
        check({tag, "_nwr"}, 64'(wlog.size()), 64'(exp_w.size()));
        n = (wlog.size() < exp_w.size()) ? wlog.size() : exp_w.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_w%0d", tag, i), 64'(wlog[i]), 64'(exp_w[i]));
        check({tag, "_strobe"}, 64'(bad_strobe), 64'd0);
    endtask

    // Starts a sequence and waits (bounded) for done_o. Optionally aborts when
    // write number abort_at appears on the bus, and pulses a stray start.
    task automatic run_seq(input string tag, input logic [AW-1:0] base, input logic [AW:0] count,
                           input int abort_at, input bit extra_start, output int cycles);
        bit aborted;
        aborted = 1'b0;
        wlog.delete();
        rlog.delete();
        done_seen  = 0;
        bad_strobe = 0;
        @(negedge wb_clk_i); #1;
        base_i  = base;
        count_i = count;
        start_i = 1'b1;
        @(negedge wb_clk_i); #1;
        start_i = 1'b0;
        base_i  = 8'h55;
        count_i = 9'd7;
        cycles  = 1;
        check({tag, "_err_clr"}, 64'(err_o), 64'd0);
        check({tag, "_busy"}, 64'(busy_o), 64'd1);
        while (!done_o && cycles < 500) begin
            abort_i = 1'b0;
            start_i = 1'b0;
            if (abort_at >= 0 && !aborted && wlog.size() == abort_at + 1) begin
                abort_i = 1'b1;
                aborted = 1'b1;
            end
            if (extra_start && cycles == 3) begin
                start_i = 1'b1;
                base_i  = 8'h40;
            end
            @(negedge wb_clk_i); #1;
            cycles++;
        end
        abort_i = 1'b0;
        start_i = 1'b0;
        check({tag, "_done"}, 64'(done_o), 64'd1);
        @(negedge wb_clk_i); #1;
        @(negedge wb_clk_i); #1;
        check({tag, "_done_once"}, 64'(done_seen), 64'd1);
        check({tag, "_idle"}, 64'({busy_o, wb_cyc_o}), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int byp;
`ifdef BQ_LOADER_SAFE_BYPASS_EN
        byp = 1;
`else
        byp = 0;
`endif
        for (int i = 0; i < 256; i++) ram[i] = {7'(i), 32'hA500_0000 | 32'(i)};
        ram[8'h10] = {7'h04, 32'h0001_2345};
        ram[8'h11] = {7'h08, 32'h0000_0ABC};
        ram[8'h12] = {7'h10, 32'h0003_FFFF};

        // Reset state
        #23;
        check("rst_wb_ctl", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 64'd0);
        check("rst_status", 64'({busy_o, done_o, err_o, prog_en_o}), 64'd0);
        check("rst_err_idx", 64'(err_idx_o), 64'd0);
        check("rst_bus", 64'({wb_adr_o, wb_dat_o, wb_sel_o}), 64'd0);
        check("rst_prog_adr", 64'(prog_adr_o), 64'd0);
        wb_rst_n_i = 1'b1;

        // Three entries, ack after 2 cycles
        tgt_lat = 2;
        run_seq("basic", 8'h10, 9'd3, -1, 1'b0, cyc);
        exp_begin();
        exp_entry(8'h10); exp_entry(8'h11); exp_entry(8'h12);
        exp_commit();
        check_writes("basic");
        check("basic_nrd", 64'(rlog.size()), 64'd3);
        if (rlog.size() == 3) check("basic_rd", 64'({rlog[0], rlog[1], rlog[2]}), 64'h10_11_12);
        check("basic_err", 64'(err_o), 64'd0);
        check("basic_cycles", 64'(cyc), 64'(16 + 2 * byp));

        // Commit only
        run_seq("cnt0", 8'h33, 9'd0, -1, 1'b0, cyc);
        exp_begin();
        exp_commit();
        check_writes("cnt0");
        check("cnt0_nrd", 64'(rlog.size()), 64'd0);
        check("cnt0_err", 64'(err_o), 64'd0);
        check("cnt0_cycles", 64'(cyc), 64'(byp ? 6 : 3));

        // Silent target: timeout on the first write
        tgt_never = 1'b1;
        run_seq("tmo", 8'h10, 9'd3, -1, 1'b0, cyc);
        tgt_never = 1'b0;
        check("tmo_nwr", 64'(wlog.size()), 64'd1);
        check("tmo_cyc_len", 64'(last_hi), 64'(TMO));
        check("tmo_err", 64'(err_o), 64'd1);
        check("tmo_err_idx", 64'(err_idx_o), 64'd0);

        // Bus error on entry 2 of 4
        tgt_err_at = 2 + byp;
        run_seq("berr", 8'h20, 9'd4, -1, 1'b0, cyc);
        tgt_err_at = -1;
        exp_begin();
        exp_entry(8'h20); exp_entry(8'h21); exp_entry(8'h22);
        check_writes("berr");
        check("berr_nrd", 64'(rlog.size()), 64'd3);
        check("berr_err", 64'(err_o), 64'd1);
        check("berr_err_idx", 64'(err_idx_o), 64'd2);

        // Abort during the second entry write, stray start while busy
        tgt_lat = 4;
        run_seq("abort", 8'h30, 9'd4, 1 + byp, 1'b1, cyc);
        exp_begin();
        exp_entry(8'h30); exp_entry(8'h31);
        check_writes("abort");
        check("abort_nrd", 64'(rlog.size()), 64'd2);
        if (rlog.size() == 2) check("abort_rd", 64'({rlog[0], rlog[1]}), 64'h30_31);
        check("abort_err", 64'(err_o), 64'd1);
        check("abort_err_idx", 64'(err_idx_o), 64'd1);

        // Program address wraps past the top of the RAM
        tgt_lat = 1;
        run_seq("wrap", 8'hFE, 9'd4, -1, 1'b0, cyc);
        exp_begin();
        exp_entry(8'hFE); exp_entry(8'hFF); exp_entry(8'h00); exp_entry(8'h01);
        exp_commit();
        check_writes("wrap");
        check("wrap_nrd", 64'(rlog.size()), 64'd4);
        if (rlog.size() == 4) check("wrap_rd", 64'({rlog[0], rlog[1], rlog[2], rlog[3]}), 64'hFE_FF_00_01);
        check("wrap_err", 64'(err_o), 64'd0);

        // Asynchronous reset while a write is outstanding
        tgt_never = 1'b1;
        @(negedge wb_clk_i); #1;
        base_i  = 8'h10;
        count_i = 9'd1;
        start_i = 1'b1;
        @(negedge wb_clk_i); #1;
        start_i = 1'b0;
        for (int i = 0; i < 10 && !wb_cyc_o; i++) begin
            @(negedge wb_clk_i); #1;
        end
        check("arst_cyc_before", 64'(wb_cyc_o), 64'd1);
        #2;
        wb_rst_n_i = 1'b0;
        #1;
        check("arst_cyc_after", 64'({wb_cyc_o, wb_stb_o, busy_o}), 64'd0);
        @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        tgt_never  = 1'b0;
        @(negedge wb_clk_i); #1;
        check("arst_idle", 64'({busy_o, wb_cyc_o, err_o}), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/biquad8_coeff_loader.md
Name: biquad8_coeff_loader

Overview:
WISHBONE master that programs one biquad8 filter slot from a coefficient program stored in block RAM. On a start pulse it fetches (address, data) entries and issues one single-beat WB write per entry to the biquad's 7-bit register space. It then issues the commit write (reg 0x00, bit0 = update) and reports done or error. Sits in the WB clock domain between the control CPU/DMA and the per-channel biquad register targets, replacing ~20 CPU-driven writes per reload.

Parameters:
PROG_ADDR_BITS, 8, program RAM address width (max 256 entries)
TIMEOUT, 255, WB ack-wait cycles before abort (1..65535)
UPDATE_WORD, 32'h0000_0001, data written to reg 0x00 for commit

Ports:
wb_clk_i  in  1  WB-domain clock; sole clock
wb_rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  one-cycle pulse; begin program (ignored unless idle)
base_i  in  PROG_ADDR_BITS  first program entry, sampled on start_i
count_i  in  PROG_ADDR_BITS+1  entries to write, sampled on start_i; 0 = commit only
abort_i  in  1  pulse; terminate sequence with error
busy_o  out  1  sequence in progress
done_o  out  1  one-cycle pulse on completion (success or error)
err_o  out  1  sticky error status of last sequence; cleared on accepted start
err_idx_o  out  PROG_ADDR_BITS+1  entry index at which error occurred
prog_adr_o  out  PROG_ADDR_BITS  program RAM read address
prog_en_o  out  1  program RAM read enable
prog_dat_i  in  39  RAM data {adr[6:0], dat[31:0]}, valid 1 cycle after prog_en_o
wb_cyc_o, wb_stb_o, wb_we_o  out  1  WB master strobes
wb_adr_o  out  7  register address
wb_dat_o  out  32  write data
wb_sel_o  out  4  byte selects
wb_ack_i, wb_err_i, wb_rty_i  in  1  WB responses

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0.
- FSM: IDLE -> FETCH (prog_en_o=1) -> LATCH (capture prog_dat_i into adr/dat regs) -> WRITE (cyc=stb=we=1, sel=4'hF, hold until response) -> FETCH for the next entry, or COMMIT after the last -> DONE -> IDLE.
- count_i=0: IDLE -> COMMIT directly.
- COMMIT: write reg 0x00, dat=UPDATE_WORD, sel=4'b0001; handled like WRITE.
- Each write completes on wb_ack_i. cyc/stb drop the cycle after ack; there is no back-to-back pipelining.
- Latency per entry: 3 cycles + ack latency.
- wb_err_i or wb_rty_i during WRITE/COMMIT: error; no retry.
- Timeout counter reloads on entering WRITE/COMMIT. Reaching TIMEOUT without a response is an error.
- Error or abort_i (any non-IDLE state):
  - deassert cyc/stb in the same cycle (registered next edge);
  - set err_o and latch err_idx_o = current index;
  - go to DONE; commit is NOT issued.
- abort_i in IDLE: ignored.
- abort_i and ack in the same cycle: abort wins; the write is counted as the error index.
- start_i while busy: ignored, no side effects.
- prog_adr_o wraps modulo 2^PROG_ADDR_BITS when base+count overflows.
- busy_o = 1 from the cycle after an accepted start through the DONE cycle.
- done_o is high in the DONE cycle only.
- Async reset mid-transfer drops cyc immediately. The target's own pending logic handles the lost cycle.

Optional Feature:
BQ_LOADER_SAFE_BYPASS_EN.
- Defined: an accepted start first performs a BYP_ENTER write before the first entry: reg 0x00, dat=32'h0080_0000, sel=4'b0101. This forces the filter into local bypass during reload.
- Defined: COMMIT instead writes dat=32'h0081_0001, sel=4'b0101, i.e. leave bypass plus update in one write.
- Defined, on error: a BYP_ENTER write that succeeded leaves the filter bypassed; no exit write is issued.
- Undefined: no BYP_ENTER state; COMMIT as described above.

Decomposition:
- Package biquad8_loader_pkg:
  - state enum;
  - register offsets (REG_CTRL 7'h00, REG_FIR 7'h04, REG_IIR 7'h08, REG_INC 7'h0C, REG_POLEFIR 7'h10);
  - control bit positions (UPDATE 0, BYP_VAL 16, BYP_APPLY 23, MASK_APPLY 31);
  - BYP_ENTER/EXIT words;
  - program entry struct {adr, dat}.
- One sub-module, biquad8_wb_single_write: single-beat WB write engine with timeout, reused for entry, bypass and commit writes.

Test Plan:
- base=0x10, count=3, RAM {04:0x1_2345, 08:0x0_0ABC, 10:0x3_FFFF}, target acks after 2 cycles -> three writes in order with sel=F, then 0x00/0x1 with sel=1, done_o pulse, err_o=0.
- count=0 -> single commit write to 0x00, done_o; no prog_en_o assertion.
- Target never acks, TIMEOUT=8 -> cyc drops 8 cycles after assertion, err_o=1, err_idx_o=0, no commit write.
- wb_err_i on entry 2 of 4 -> err_idx_o=2, entries 3 and commit not issued; next start clears err_o.
- abort_i during second WRITE; start_i while busy -> abort ends sequence with err; extra start has no effect; base=0xFE, count=4 reads 0xFE,0xFF,0x00,0x01.
- With BQ_LOADER_SAFE_BYPASS_EN -> first write 0x00/0x0080_0000 sel 5, final write 0x00/0x0081_0001 sel 5.
